// File: rtl/sramqsys_dataout_fifo_if.sv
// Bus bundle for sramqsys_dataout_fifo: Avalon-MM register port plus the
// out_port/out_valid/out_ready drain handshake.
// Optional feature macro: SRAMQSYS_DATAOUT_IRQ_EN adds the irq line.
interface sramqsys_dataout_fifo_if #(
    parameter int DATA_W = 8
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_port;
    logic              out_valid;
    logic              out_ready;
`ifdef SRAMQSYS_DATAOUT_IRQ_EN
    logic              irq;

    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_port, out_valid, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_port, out_valid, irq
    );
`else
    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_port, out_valid
    );

    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_port, out_valid
    );
`endif
endinterface

// File: rtl/sramqsys_dataout_fifo.sv
// sramqsys_dataout_fifo: Avalon-MM slave transmit FIFO. Software pushes bytes
// through the DATA register; they drain to fabric logic over out_valid/out_ready
// while drain_en is set. STATUS exposes count/ovf/full/empty, CONTROL holds
// drain_en and a flush pulse.
// Optional feature macro: SRAMQSYS_DATAOUT_IRQ_EN adds CONTROL bit2 irq_en and
// a registered irq output (irq_en & (empty | ovf)).
module sramqsys_dataout_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    sramqsys_dataout_fifo_if.slave  bus
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [AW:0]       count;
    logic              ovf;
    logic              drain_en;
`ifdef SRAMQSYS_DATAOUT_IRQ_EN
    logic              irq_en;
    logic              irq_q;
`endif

    logic              wr_en;
    logic              push_req;
    logic              ctrl_wr;
    logic              flush;
    logic              ovf_clr;
    logic              ovf_set;
    logic              do_push;
    logic              do_pop;
    logic              full;
    logic              empty;
    logic              out_valid_int;
    logic [DATA_W-1:0] head;
    logic [31:0]       status_word;
    logic [31:0]       control_word;
    logic [31:0]       rd_mux;

    // Upper writedata bits beyond the byte lane carry no meaning for this block.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:DATA_W];

    // Register-write decode and FIFO push/pop qualification.
    always_comb begin
        wr_en    = bus.chipselect & ~bus.write_n;
        push_req = wr_en && (bus.address == ADDR_DATA);
        ctrl_wr  = wr_en && (bus.address == ADDR_CONTROL);
        flush    = ctrl_wr & bus.writedata[1];
        ovf_clr  = wr_en && (bus.address == ADDR_STATUS) && bus.writedata[2];

        full          = (count == FULL_COUNT);
        empty         = (count == '0);
        out_valid_int = drain_en & ~empty;

        // A pop frees a slot this cycle, so a push onto a full FIFO with a
        // simultaneous pop is accepted and does not count as overflow.
        do_pop  = out_valid_int & bus.out_ready;
        do_push = push_req & (~full | do_pop);
        ovf_set = push_req & full & ~do_pop;
    end

    // Show-ahead head byte; an empty FIFO presents zero.
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr];
        end
    end

    // Storage write; entries are not reset, emptiness is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= bus.writedata[DATA_W-1:0];
        end
    end

    // Pointers and fill count; flush wins over any pop on the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow beats a same-cycle W1C clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // CONTROL register; the flush bit is a pulse and is not stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_en <= 1'b0;
`ifdef SRAMQSYS_DATAOUT_IRQ_EN
            irq_en   <= 1'b0;
`endif
        end else if (ctrl_wr) begin
            drain_en <= bus.writedata[0];
`ifdef SRAMQSYS_DATAOUT_IRQ_EN
            irq_en   <= bus.writedata[2];
`endif
        end
    end

`ifdef SRAMQSYS_DATAOUT_IRQ_EN
    // Interrupt registered from current state, so it lags the condition by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_en & (empty | ovf);
        end
    end

    assign bus.irq = irq_q;
`endif

    // Readback words assembled from current register state.
    always_comb begin
        status_word              = '0;
        status_word[AW+8:8]      = count;
        status_word[2]           = ovf;
        status_word[1]           = full;
        status_word[0]           = empty;

        control_word             = '0;
        control_word[0]          = drain_en;
`ifdef SRAMQSYS_DATAOUT_IRQ_EN
        control_word[2]          = irq_en;
`endif

        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux[DATA_W-1:0] = head;
            ADDR_STATUS:  rd_mux = status_word;
            ADDR_CONTROL: rd_mux = control_word;
            default:      rd_mux = '0;
        endcase
    end

    // Read data registered every cycle from address, without chipselect gating.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign bus.out_port  = head;
    assign bus.out_valid = out_valid_int;

endmodule

// File: tb/tb_sramqsys_dataout_fifo.sv
// Testbench for sramqsys_dataout_fifo: directed scenarios plus randomized
// traffic, checked against a queue-based reference model.
// Optional feature macro: SRAMQSYS_DATAOUT_IRQ_EN enables the irq scenario.
module tb_sramqsys_dataout_fifo;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sramqsys_dataout_fifo_if #(.DATA_W(8)) bus ();

    sramqsys_dataout_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH),
        .AW     (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0]  q[$];
    bit          m_ovf;
    bit          m_drain;
    bit          m_irq_en;
    logic        exp_irq;
    logic [31:0] exp_rd;

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] v;
        v = '0;
        case (a)
            2'd0: if (q.size() != 0) v[7:0] = q[0];
            2'd1: begin
                v    = 32'(q.size()) << 8;
                v[2] = m_ovf;
                v[1] = (q.size() == DEPTH);
                v[0] = (q.size() == 0);
            end
            2'd2: begin
                v[0] = m_drain;
                v[2] = m_irq_en;
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic exp_valid();
        return m_drain && (q.size() != 0);
    endfunction

    function automatic logic [7:0] exp_port();
        return (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    // One clock of stimulus; the model advances by the register-map rules.
    task automatic step(input logic cs, input logic wn, input logic [1:0] a,
                        input logic [31:0] wd, input logic rdy);
        bit wr, pop, set_ovf;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.address    = a;
        bus.writedata  = wd;
        bus.out_ready  = rdy;
        exp_rd  = model_read(a);
        exp_irq = m_irq_en && ((q.size() == 0) || m_ovf);
        wr      = cs && !wn;
        pop     = exp_valid() && rdy;
        set_ovf = 1'b0;
        if (wr && a == 2'd2 && wd[1]) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (wr && a == 2'd0) begin
                if (q.size() < DEPTH) q.push_back(wd[7:0]);
                else set_ovf = 1'b1;
            end
        end
        if (set_ovf) m_ovf = 1'b1;
        else if (wr && a == 2'd1 && wd[2]) m_ovf = 1'b0;
        if (wr && a == 2'd2) begin
            m_drain = wd[0];
`ifdef SRAMQSYS_DATAOUT_IRQ_EN
            m_irq_en = wd[2];
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        step(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        step(1'b0, 1'b1, a, 32'h0, 1'b0);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        q.delete();
        m_ovf    = 1'b0;
        m_drain  = 1'b0;
        m_irq_en = 1'b0;
        exp_irq  = 1'b0;
        exp_rd   = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (bus.readdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_readdata: got %h expected %h", bus.readdata, 32'h0);
        end
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        n_vec++;
        if (bus.out_port !== 8'h00) begin
            n_bad++; $display("FAIL reset_out_port: got %h expected 00", bus.out_port);
        end
        rd_reg(2'd1);
        n_vec++;
        if (bus.readdata !== 32'h1) begin
            n_bad++; $display("FAIL reset_status: got %h expected %h", bus.readdata, 32'h1);
        end
        rd_reg(2'd2);
        n_vec++;
        if (bus.readdata !== 32'h0) begin
            n_bad++; $display("FAIL reset_control: got %h expected %h", bus.readdata, 32'h0);
        end
    endtask

    task automatic test_basic_drain();
        do_reset();
        wr_reg(2'd0, 32'hA5);
        wr_reg(2'd0, 32'h3C);
        rd_reg(2'd1);
        n_vec++;
        if (bus.readdata !== 32'h200) begin
            n_bad++; $display("FAIL basic_status_count2: got %h expected %h", bus.readdata, 32'h200);
        end
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_gated_valid: got %b expected 0", bus.out_valid);
        end
        rd_reg(2'd0);
        n_vec++;
        if (bus.readdata !== 32'hA5) begin
            n_bad++; $display("FAIL basic_data_head: got %h expected %h", bus.readdata, 32'hA5);
        end
        step(1'b1, 1'b0, 2'd2, 32'h1, 1'b1);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_port !== 8'hA5) begin
            n_bad++; $display("FAIL basic_first_byte: got v=%b %h expected v=1 a5", bus.out_valid, bus.out_port);
        end
        step(1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.out_port !== 8'h3C) begin
            n_bad++; $display("FAIL basic_second_byte: got v=%b %h expected v=1 3c", bus.out_valid, bus.out_port);
        end
        step(1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL basic_drained: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_full_overflow();
        do_reset();
        wr_reg(2'd2, 32'h1);
        for (int i = 0; i < DEPTH; i++) begin
            wr_reg(2'd0, 32'(i));
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_port !== 8'h00) begin
                n_bad++; $display("FAIL full_head_held[%0d]: got v=%b %h expected v=1 00", i, bus.out_valid, bus.out_port);
            end
        end
        rd_reg(2'd1);
        n_vec++;
        if (bus.readdata !== 32'h1002) begin
            n_bad++; $display("FAIL full_status: got %h expected %h", bus.readdata, 32'h1002);
        end
        wr_reg(2'd0, 32'hEE);
        rd_reg(2'd1);
        n_vec++;
        if (bus.readdata !== 32'h1006) begin
            n_bad++; $display("FAIL overflow_status: got %h expected %h", bus.readdata, 32'h1006);
        end
        wr_reg(2'd1, 32'h4);
        rd_reg(2'd1);
        n_vec++;
        if (bus.readdata !== 32'h1002) begin
            n_bad++; $display("FAIL ovf_w1c: got %h expected %h", bus.readdata, 32'h1002);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] want;
        step(1'b1, 1'b0, 2'd0, 32'h77, 1'b1);
        rd_reg(2'd1);
        n_vec++;
        if (bus.readdata !== 32'h1002) begin
            n_bad++; $display("FAIL pushpop_full_status: got %h expected %h", bus.readdata, 32'h1002);
        end
        for (int i = 0; i < DEPTH; i++) begin
            want = (i < DEPTH - 1) ? 8'(i + 1) : 8'h77;
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_port !== want) begin
                n_bad++; $display("FAIL pushpop_order[%0d]: got v=%b %h expected v=1 %h", i, bus.out_valid, bus.out_port, want);
            end
            step(1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
        end
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL pushpop_empty: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) wr_reg(2'd0, 32'h50 + 32'(i));
        wr_reg(2'd2, 32'h3);
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_valid: got %b expected 0", bus.out_valid);
        end
        rd_reg(2'd1);
        n_vec++;
        if (bus.readdata !== 32'h1) begin
            n_bad++; $display("FAIL flush_status: got %h expected %h", bus.readdata, 32'h1);
        end
        rd_reg(2'd2);
        n_vec++;
        if (bus.readdata !== 32'h1) begin
            n_bad++; $display("FAIL flush_control: got %h expected %h", bus.readdata, 32'h1);
        end
    endtask

    task automatic test_reset_midtransfer();
        do_reset();
        wr_reg(2'd2, 32'h1);
        wr_reg(2'd0, 32'h11);
        wr_reg(2'd0, 32'h22);
        wr_reg(2'd0, 32'h33);
        step(1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL midreset_valid: got %b expected 0", bus.out_valid);
        end
        do_reset();
        rd_reg(2'd1);
        n_vec++;
        if (bus.readdata !== 32'h1) begin
            n_bad++; $display("FAIL midreset_status: got %h expected %h", bus.readdata, 32'h1);
        end
    endtask

`ifdef SRAMQSYS_DATAOUT_IRQ_EN
    task automatic test_irq();
        do_reset();
        wr_reg(2'd2, 32'h5);
        rd_reg(2'd2);
        n_vec++;
        if (bus.irq !== 1'b1) begin
            n_bad++; $display("FAIL irq_empty: got %b expected 1", bus.irq);
        end
        n_vec++;
        if (bus.readdata !== 32'h5) begin
            n_bad++; $display("FAIL irq_control: got %h expected %h", bus.readdata, 32'h5);
        end
        wr_reg(2'd0, 32'h9A);
        rd_reg(2'd1);
        n_vec++;
        if (bus.irq !== 1'b0) begin
            n_bad++; $display("FAIL irq_nonempty: got %b expected 0", bus.irq);
        end
    endtask
`endif

    task automatic test_random();
        logic        cs, wn, rdy;
        logic [1:0]  a;
        logic [31:0] wd;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            cs  = ($urandom_range(0, 3) != 0);
            wn  = ($urandom_range(0, 2) == 0);
            a   = 2'($urandom_range(0, 3));
            wd  = $urandom;
            if (a == 2'd2) wd[1] = ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 2) == 0);
            step(cs, wn, a, wd, rdy);
            n_vec++;
            if (bus.readdata !== exp_rd) begin
                n_bad++; $display("FAIL rand_readdata[%0d]: got %h expected %h", i, bus.readdata, exp_rd);
            end
            n_vec++;
            if (bus.out_valid !== exp_valid()) begin
                n_bad++; $display("FAIL rand_out_valid[%0d]: got %b expected %b", i, bus.out_valid, exp_valid());
            end
            n_vec++;
            if (bus.out_port !== exp_port()) begin
                n_bad++; $display("FAIL rand_out_port[%0d]: got %h expected %h", i, bus.out_port, exp_port());
            end
`ifdef SRAMQSYS_DATAOUT_IRQ_EN
            n_vec++;
            if (bus.irq !== exp_irq) begin
                n_bad++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, bus.irq, exp_irq);
            end
`endif
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = '0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_basic_drain();
        test_full_overflow();
        test_push_pop_full();
        test_flush();
        test_reset_midtransfer();
`ifdef SRAMQSYS_DATAOUT_IRQ_EN
        test_irq();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
